// File: rtl/alu_pkg.sv
// Shared encodings and bounds for the byte-serial ALU sequencer.
// Combinational definitions only; no latency or flow control of its own.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int BYTES_MIN = 1;
    localparam int BYTES_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between two requesters, a response consumer and the sequencer.
// Valid/ready on both the request side and the response side.
interface alu_op_sequencer_if #(
    parameter int BYTES = 2
);
    localparam int W = 8 * BYTES;

    logic         req0_valid;
    logic         req0_ready;
    logic         req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic         req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_ovf;
    logic         rsp_zero;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero
    );

endinterface

// File: rtl/alu_byte_slice.sv
// 8-bit adder slice with carry in/out, shared across all byte passes.
// Purely combinational: zero latency, no flow control.
module alu_byte_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/alu_op_sequencer.sv
// Round-robin arbiter + byte-serial add/sub over one shared 8-bit slice; BYTES+1 cycles accept-to-response.
// Requests stall (ready low) outside IDLE; the response is held stable until rsp_ready.
module alu_op_sequencer #(
    parameter int BYTES = 2
) (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus
);
    import alu_pkg::*;

    localparam int         W    = 8 * BYTES;
    localparam logic [1:0] LAST = 2'(BYTES - 1);

    generate
        if (BYTES < BYTES_MIN || BYTES > BYTES_MAX) begin : g_bad_bytes
            $error("alu_op_sequencer: BYTES out of range");
        end
    endgenerate

    state_t       state;
    logic         last_grant;
    logic [1:0]   idx;
    logic [W-1:0] a_sr;
    logic [W-1:0] b_sr;
    logic [W-1:0] r_sr;
    logic         op_q;
    logic         id_q;
    logic         c_q;
    logic         a_msb;
    logic         bp_msb;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_result_q;
    logic         rsp_carry_q;
    logic         rsp_ovf_q;
    logic         rsp_zero_q;

    logic         grant0;
    logic         grant1;
    logic [7:0]   sum;
    logic         cout;
    logic [W+7:0] r_cat;
    logic [W-1:0] r_next;

    // Ties go to whichever requester was not granted last; held low while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset && state == IDLE) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    alu_byte_slice u_slice (
        .a    (a_sr[7:0]),
        .b    (b_sr[7:0] ^ {8{op_q}}),
        .cin  (c_q),
        .sum  (sum),
        .cout (cout)
    );

    // Result fills from the top so the finished word lands aligned after the last pass.
    assign r_cat  = {sum, r_sr};
    assign r_next = r_cat[W+7:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            idx          <= '0;
            a_sr         <= '0;
            b_sr         <= '0;
            r_sr         <= '0;
            op_q         <= OP_ADD;
            id_q         <= 1'b0;
            c_q          <= 1'b0;
            a_msb        <= 1'b0;
            bp_msb       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_q       <= grant1 ? bus.req1_op : bus.req0_op;
                        a_sr       <= grant1 ? bus.req1_a  : bus.req0_a;
                        b_sr       <= grant1 ? bus.req1_b  : bus.req0_b;
                        c_q        <= (grant1 ? bus.req1_op : bus.req0_op) == OP_SUB;
                        a_msb      <= grant1 ? bus.req1_a[W-1] : bus.req0_a[W-1];
                        bp_msb     <= grant1 ? (bus.req1_b[W-1] ^ bus.req1_op)
                                             : (bus.req0_b[W-1] ^ bus.req0_op);
                        id_q       <= grant1;
                        last_grant <= grant1;
                        idx        <= '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    a_sr <= a_sr >> 8;
                    b_sr <= b_sr >> 8;
                    r_sr <= r_next;
                    c_q  <= cout;
                    idx  <= idx + 2'd1;
                    if (idx == LAST) begin
                        state        <= DONE;
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= id_q;
                        rsp_result_q <= r_next;
                        rsp_carry_q  <= cout ^ op_q;
                        rsp_ovf_q    <= (a_msb == bp_msb) && (r_next[W-1] != a_msb);
                        rsp_zero_q   <= ~|r_next;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer at BYTES = 2 with hand-computed expectations.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.BYTES(2)) bus ();
    alu_op_sequencer #(.BYTES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  lat;
        logic        id;
        logic        c;
        logic        o;
        logic        z;
        logic [15:0] res;
    } obs_t;

    function automatic obs_t ex(input logic id, input logic c, input logic o,
                                input logic z, input logic [15:0] r);
        ex = {8'd3, id, c, o, z, r};
    endfunction

    // Requesters must hold valid and operands until ready.
    logic        h0 = 1'b0, h1 = 1'b0;
    logic [32:0] d0, d1;
    always @(posedge clk) begin
        if (!reset) begin
            h0 = 1'b0;
            h1 = 1'b0;
        end else begin
            if (h0) assert (bus.req0_valid && {bus.req0_op, bus.req0_a, bus.req0_b} == d0)
                else $error("req0 dropped or changed before ready");
            if (h1) assert (bus.req1_valid && {bus.req1_op, bus.req1_a, bus.req1_b} == d1)
                else $error("req1 dropped or changed before ready");
            h0 = bus.req0_valid && !bus.req0_ready;
            d0 = {bus.req0_op, bus.req0_a, bus.req0_b};
            h1 = bus.req1_valid && !bus.req1_ready;
            d1 = {bus.req1_op, bus.req1_a, bus.req1_b};
        end
    end

    task automatic run_op(input bit rq, input logic op, input logic [15:0] a,
                          input logic [15:0] b, output obs_t obs);
        int k;
        obs = '0;
        @(negedge clk);
        if (!rq) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        bus.rsp_ready = 1'b1;
        #1;
        k = 0;
        while (!(rq ? bus.req1_ready : bus.req0_ready) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        obs.lat = 8'd1;
        while (!bus.rsp_valid && obs.lat < 8'd20) begin
            @(negedge clk);
            obs.lat++;
        end
        if (k >= 20) obs.lat = 8'hFE;
        obs.id  = bus.rsp_id;
        obs.c   = bus.rsp_carry;
        obs.o   = bus.rsp_ovf;
        obs.z   = bus.rsp_zero;
        obs.res = bus.rsp_result;
    endtask

    task automatic test_reset;
        logic [20:0] outs;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready});
        end
        outs = {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero, bus.rsp_result};
        checks++;
        if (outs !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add_basic;
        obs_t o;
        run_op(1'b0, OP_ADD, 16'h00FF, 16'h0001, o);
        checks++;
        if (o !== ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100)) begin
            failures++;
            $display("FAIL add_00ff_0001 got=%h exp=%h", o, ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100));
        end
    endtask

    task automatic test_sub;
        obs_t o;
        run_op(1'b1, OP_SUB, 16'h1234, 16'h1234, o);
        checks++;
        if (o !== ex(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000)) begin
            failures++;
            $display("FAIL sub_equal got=%h exp=%h", o, ex(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000));
        end
        run_op(1'b1, OP_SUB, 16'h0000, 16'h0001, o);
        checks++;
        if (o !== ex(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF)) begin
            failures++;
            $display("FAIL sub_borrow got=%h exp=%h", o, ex(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF));
        end
    endtask

    task automatic test_overflow;
        obs_t o;
        run_op(1'b0, OP_ADD, 16'h7FFF, 16'h0001, o);
        checks++;
        if (o !== ex(1'b0, 1'b0, 1'b1, 1'b0, 16'h8000)) begin
            failures++;
            $display("FAIL add_signed_ovf got=%h exp=%h", o, ex(1'b0, 1'b0, 1'b1, 1'b0, 16'h8000));
        end
        run_op(1'b0, OP_ADD, 16'hFFFF, 16'h0001, o);
        checks++;
        if (o !== ex(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000)) begin
            failures++;
            $display("FAIL add_carry_wrap got=%h exp=%h", o, ex(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000));
        end
    endtask

    task automatic test_back_to_back;
        int          gcyc[$];
        bit          gid[$];
        int          rcyc[$];
        logic [16:0] rval[$];
        logic [16:0] rexp;
        @(negedge clk);
        reset = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002;
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 16'h0005; bus.req1_b = 16'h0003;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus.req0_ready) begin gcyc.push_back(cyc); gid.push_back(1'b0); end
            if (bus.req1_ready) begin gcyc.push_back(cyc); gid.push_back(1'b1); end
            if (bus.rsp_valid) begin
                rcyc.push_back(cyc);
                rval.push_back({bus.rsp_id, bus.rsp_result});
            end
            @(negedge clk); #1;
        end
        checks++;
        if (gcyc.size() != 4) begin
            failures++;
            $display("FAIL b2b_grant_count got=%0d exp=4", gcyc.size());
        end
        for (int g = 0; g < 4 && g < gcyc.size(); g++) begin
            checks++;
            if (gcyc[g] != 4 * g || gid[g] != g[0]) begin
                failures++;
                $display("FAIL b2b_grant_%0d got=cyc%0d/id%0d exp=cyc%0d/id%0d",
                         g, gcyc[g], gid[g], 4 * g, g[0]);
            end
        end
        checks++;
        if (rcyc.size() != 4) begin
            failures++;
            $display("FAIL b2b_rsp_count got=%0d exp=4", rcyc.size());
        end
        for (int g = 0; g < 4 && g < rcyc.size(); g++) begin
            rexp = g[0] ? 17'h1_0002 : 17'h0_0003;
            checks++;
            if (rcyc[g] != 4 * g + 3 || rval[g] !== rexp) begin
                failures++;
                $display("FAIL b2b_rsp_%0d got=cyc%0d/%h exp=cyc%0d/%h",
                         g, rcyc[g], rval[g], 4 * g + 3, rexp);
            end
        end
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_backpressure;
        logic [19:0] snap;
        logic [22:0] cur;
        obs_t        o;
        int          k;
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h1234; bus.req0_b = 16'h0101;
        #1;
        k = 0;
        while (!bus.req0_ready && k < 20) begin @(negedge clk); #1; k++; end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 16'h0010; bus.req1_b = 16'h0020;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin @(negedge clk); k++; end
        snap = {bus.rsp_id, bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero, bus.rsp_result};
        checks++;
        if (snap !== 20'h0_1335) begin
            failures++;
            $display("FAIL bp_first_rsp got=%h exp=01335", snap);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cur = {bus.rsp_valid, bus.req0_ready, bus.req1_ready,
                   bus.rsp_id, bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero, bus.rsp_result};
            checks++;
            if (cur !== {3'b100, 20'h0_1335}) begin
                failures++;
                $display("FAIL bp_hold_%0d got=%h exp=%h", i, cur, {3'b100, 20'h0_1335});
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_in_done got=%b exp=0", bus.req1_ready);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_next_accept got=%b exp=01", {bus.rsp_valid, bus.req1_ready});
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        o = '0;
        o.lat = 8'd1;
        while (!bus.rsp_valid && o.lat < 8'd20) begin @(negedge clk); o.lat++; end
        o.id = bus.rsp_id; o.c = bus.rsp_carry; o.o = bus.rsp_ovf; o.z = bus.rsp_zero;
        o.res = bus.rsp_result;
        checks++;
        if (o !== ex(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFF0)) begin
            failures++;
            $display("FAIL bp_second_rsp got=%h exp=%h", o, ex(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFF0));
        end
    endtask

    task automatic test_reset_mid_exec;
        logic [20:0] outs;
        obs_t        o;
        int          k;
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0001;
        #1;
        k = 0;
        while (!bus.req0_ready && k < 20) begin @(negedge clk); #1; k++; end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001;
        #1;
        outs = {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero, bus.rsp_result};
        checks++;
        if (outs !== 21'h0) begin
            failures++;
            $display("FAIL midexec_outputs got=%h exp=0", outs);
        end
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL midexec_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready});
        end
        bus.req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL midexec_no_rsp_%0d got=%b exp=0", i, bus.rsp_valid);
            end
        end
        run_op(1'b0, OP_ADD, 16'h0001, 16'h0001, o);
        checks++;
        if (o !== ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0002)) begin
            failures++;
            $display("FAIL midexec_after_add got=%h exp=%h", o, ex(1'b0, 1'b0, 1'b0, 1'b0, 16'h0002));
        end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_op = OP_ADD; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = OP_ADD; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        test_add_basic;
        test_sub;
        test_overflow;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_exec;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
